// File: rtl/forth_stack_ctrl.sv
// rtl/forth_stack_ctrl.sv - data/return stack controller caching TOS/NOS in registers and spilling deeper entries to RAM
// Optional synchronous clear port enabled by defining STACK_SYNC_CLEAR_EN.
module forth_stack_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clock,
  input  logic                    reset,
`ifdef STACK_SYNC_CLEAR_EN
  input  logic                    clear,
`endif
  input  logic                    op_valid,
  input  logic [2:0]              op,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    op_ready,
  output logic [DATA_WIDTH-1:0]   tos,
  output logic [DATA_WIDTH-1:0]   nos,
  output logic [ADDR_WIDTH+1:0]   depth,
  output logic                    empty,
  output logic                    full,
  output logic                    overflow,
  output logic                    underflow,
  output logic [DATA_WIDTH-1:0]   mem_data,
  output logic [ADDR_WIDTH-1:0]   mem_write_addr,
  output logic [ADDR_WIDTH-1:0]   mem_read_addr,
  output logic                    mem_we,
  input  logic [DATA_WIDTH-1:0]   mem_q
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_REPL  = 3'd6;
  localparam logic [2:0] OP_BINOP = 3'd7;

  localparam int                    MAX_DEPTH  = (1 << ADDR_WIDTH) + 2;
  localparam logic [ADDR_WIDTH+1:0] DEPTH_FULL = MAX_DEPTH[ADDR_WIDTH+1:0];
  localparam logic [ADDR_WIDTH+1:0] DEPTH_ONE  = {{(ADDR_WIDTH+1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH+1:0] DEPTH_TWO  = {{ADDR_WIDTH{1'b0}}, 2'b10};

  typedef enum logic {READY, LOAD} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   sp;
  logic [ADDR_WIDTH:0]   sp_dec;
  logic                  clr;
  logic                  accept;
  logic                  has_one;
  logic                  has_two;
  logic                  deep;
  logic                  at_full;
  logic                  underflow_req;
  logic                  overflow_req;
  logic                  exec;
  logic                  grows;
  logic                  shrinks;
  logic                  spill;
  logic                  refill;

`ifdef STACK_SYNC_CLEAR_EN
  assign clr = clear;
`else
  assign clr = 1'b0;
`endif

  assign sp_dec  = sp - 1'b1;
  assign has_one = depth >= DEPTH_ONE;
  assign has_two = depth >= DEPTH_TWO;
  assign deep    = depth > DEPTH_TWO;
  assign at_full = depth == DEPTH_FULL;
  assign empty   = depth == '0;
  assign full    = at_full;
  assign accept  = op_valid & op_ready & ~clr;

  // Precondition checks: underflow takes precedence, an empty stack cannot be full anyway.
  always_comb begin
    underflow_req = 1'b0;
    overflow_req  = 1'b0;
    if (accept) begin
      case (op)
        OP_PUSH:            overflow_req = at_full;
        OP_POP, OP_REPL:    underflow_req = ~has_one;
        OP_DUP: begin
          underflow_req = ~has_one;
          overflow_req  = has_one & at_full;
        end
        OP_SWAP, OP_BINOP:  underflow_req = ~has_two;
        OP_OVER: begin
          underflow_req = ~has_two;
          overflow_req  = has_two & at_full;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    exec    = accept & ~underflow_req & ~overflow_req;
    grows   = exec & ((op == OP_PUSH) | (op == OP_DUP) | (op == OP_OVER));
    shrinks = exec & ((op == OP_POP) | (op == OP_BINOP));
    spill   = grows & has_two;
    refill  = shrinks & deep;
  end

  // The read issued in the accept cycle returns in LOAD, when nos captures it.
  assign mem_we         = spill;
  assign mem_write_addr = spill  ? sp[ADDR_WIDTH-1:0]     : '0;
  assign mem_data       = spill  ? nos                    : '0;
  assign mem_read_addr  = refill ? sp_dec[ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= READY;
      op_ready  <= 1'b1;
      sp        <= '0;
      depth     <= '0;
      tos       <= '0;
      nos       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= overflow  | overflow_req;
      underflow <= underflow | underflow_req;
      if (clr) begin
        state    <= READY;
        op_ready <= 1'b1;
        sp       <= '0;
        depth    <= '0;
      end else begin
        case (state)
          READY: begin
            if (exec) begin
              case (op)
                OP_PUSH: begin
                  nos <= tos;
                  tos <= din;
                end
                OP_POP:  tos <= nos;
                OP_DUP:  nos <= tos;
                OP_SWAP, OP_OVER: begin
                  tos <= nos;
                  nos <= tos;
                end
                OP_REPL, OP_BINOP: tos <= din;
                default: ;
              endcase
              if (spill)
                sp <= sp + 1'b1;
              if (grows)
                depth <= depth + 1'b1;
              if (shrinks)
                depth <= depth - 1'b1;
              if (refill) begin
                sp       <= sp_dec;
                state    <= LOAD;
                op_ready <= 1'b0;
              end
            end
          end
          LOAD: begin
            nos      <= mem_q;
            state    <= READY;
            op_ready <= 1'b1;
          end
          default: begin
            state    <= READY;
            op_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_forth_stack_ctrl.sv
// tb/tb_forth_stack_ctrl.sv - directed and randomized checks of forth_stack_ctrl against a queue-based stack model
// Exercises the clear port when STACK_SYNC_CLEAR_EN is defined.
module tb_forth_stack_ctrl;

  localparam int DW  = 16;
  localparam int AW  = 2;
  localparam int CAP = (1 << AW) + 2;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_OVER  = 3'd5;
  localparam logic [2:0] OP_REPL  = 3'd6;
  localparam logic [2:0] OP_BINOP = 3'd7;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
`ifdef STACK_SYNC_CLEAR_EN
  logic          clear = 1'b0;
`endif
  logic          op_valid = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [DW-1:0] din = '0;
  logic          op_ready;
  logic [DW-1:0] tos;
  logic [DW-1:0] nos;
  logic [AW+1:0] depth;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic [DW-1:0] mem_data;
  logic [AW-1:0] mem_write_addr;
  logic [AW-1:0] mem_read_addr;
  logic          mem_we;
  logic [DW-1:0] mem_q = '0;

  forth_stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef STACK_SYNC_CLEAR_EN
    .clear          (clear),
`endif
    .op_valid       (op_valid),
    .op             (op),
    .din            (din),
    .op_ready       (op_ready),
    .tos            (tos),
    .nos            (nos),
    .depth          (depth),
    .empty          (empty),
    .full           (full),
    .overflow       (overflow),
    .underflow      (underflow),
    .mem_data       (mem_data),
    .mem_write_addr (mem_write_addr),
    .mem_read_addr  (mem_read_addr),
    .mem_we         (mem_we),
    .mem_q          (mem_q)
  );

  always #5 clock = ~clock;

  // Downstream dual-port RAM with registered read data.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
  always @(posedge clock) begin
    if (mem_we) ram[mem_write_addr] <= mem_data;
    mem_q <= ram[mem_read_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] stk [$];
  bit m_ovf;
  bit m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    int n;
    n = stk.size();
    chk({tag, ".op_ready"},  32'(op_ready), 32'd1);
    chk({tag, ".depth"},     32'(depth), 32'(n));
    chk({tag, ".empty"},     32'(empty), 32'(n == 0));
    chk({tag, ".full"},      32'(full), 32'(n == CAP));
    chk({tag, ".overflow"},  32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
    if (n >= 1) chk({tag, ".tos"}, 32'(tos), 32'(stk[n-1]));
    if (n >= 2) chk({tag, ".nos"}, 32'(nos), 32'(stk[n-2]));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    op_valid = 1'b0;
    op       = OP_NOP;
    din      = '0;
    reset    = 1'b1;
    #1;
    chk({tag, ".rst_ready"}, 32'(op_ready), 32'd1);
    chk({tag, ".rst_depth"}, 32'(depth), 32'd0);
    chk({tag, ".rst_tos"},   32'(tos), 32'd0);
    chk({tag, ".rst_nos"},   32'(nos), 32'd0);
    chk({tag, ".rst_flags"}, 32'({overflow, underflow}), 32'd0);
    chk({tag, ".rst_mem"},   32'({mem_we, mem_write_addr, mem_read_addr}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Applies one operation to the model, checks the RAM port activity of the
  // accept cycle, then checks op_ready timing and the resulting stack.
  task automatic do_op(input logic [2:0] o, input logic [DW-1:0] d, input string tag);
    int n;
    bit spill, load, ov, un;
    logic [DW-1:0] nos_pre, t;
    n = stk.size();
    spill = 0; load = 0; ov = 0; un = 0;
    nos_pre = (n >= 2) ? stk[n-2] : '0;
    case (o)
      OP_PUSH:  if (n == CAP) ov = 1; else begin spill = (n >= 2); stk.push_back(d); end
      OP_POP:   if (n < 1) un = 1; else begin load = (n > 2); void'(stk.pop_back()); end
      OP_DUP:   if (n < 1) un = 1; else if (n == CAP) ov = 1;
                else begin spill = (n >= 2); stk.push_back(stk[n-1]); end
      OP_SWAP:  if (n < 2) un = 1; else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
      OP_OVER:  if (n < 2) un = 1; else if (n == CAP) ov = 1;
                else begin spill = 1; stk.push_back(stk[n-2]); end
      OP_REPL:  if (n < 1) un = 1; else stk[n-1] = d;
      OP_BINOP: if (n < 2) un = 1; else begin load = (n > 2); void'(stk.pop_back()); stk[n-2] = d; end
      default: ;
    endcase
    m_ovf |= ov;
    m_unf |= un;
    @(negedge clock);
    op_valid = 1'b1;
    op       = o;
    din      = d;
    #1;
    chk({tag, ".ready_pre"}, 32'(op_ready), 32'd1);
    chk({tag, ".mem_we"},    32'(mem_we), 32'(spill));
    if (spill) begin
      chk({tag, ".waddr"}, 32'(mem_write_addr), 32'(n - 2));
      chk({tag, ".wdata"}, 32'(mem_data), 32'(nos_pre));
    end
    if (load) chk({tag, ".raddr"}, 32'(mem_read_addr), 32'(n - 3));
    @(negedge clock);
    op_valid = 1'b0;
    op       = OP_NOP;
    chk({tag, ".ready_post"}, 32'(op_ready), 32'(!load));
    if (load) @(negedge clock);
    check_state(tag);
  endtask

  initial begin
    logic [2:0] ro;

    do_reset("init");

    // Spill and refill basics
    do_op(OP_PUSH, 16'h0011, "push1");
    do_op(OP_PUSH, 16'h0022, "push2");
    do_op(OP_PUSH, 16'h0033, "push3");
    chk("tp1.tos", 32'(tos), 32'h0033);
    chk("tp1.nos", 32'(nos), 32'h0022);
    do_op(OP_POP, 16'h0000, "pop_load");
    chk("tp2.tos", 32'(tos), 32'h0022);
    chk("tp2.nos", 32'(nos), 32'h0011);
    do_op(OP_PUSH, 16'h0033, "push4");
    do_op(OP_BINOP, 16'h0055, "binop_load");
    chk("tp3.tos", 32'(tos), 32'h0055);
    chk("tp3.nos", 32'(nos), 32'h0011);
    do_op(OP_POP, 16'h0000, "pop_d2");

    // SWAP then OVER at depth 2
    do_reset("r_swap");
    do_op(OP_PUSH, 16'h0011, "sw_p1");
    do_op(OP_PUSH, 16'h0022, "sw_p2");
    do_op(OP_SWAP, 16'h0000, "swap");
    chk("tp4.swap_tos", 32'(tos), 32'h0011);
    do_op(OP_OVER, 16'h0000, "over");
    chk("tp4.over_tos", 32'(tos), 32'h0022);
    chk("tp4.over_nos", 32'(nos), 32'h0011);

    // Underflow on empty stack
    do_reset("r_unf");
    do_op(OP_POP, 16'h0000, "pop_empty");
    chk("tp5.underflow", 32'(underflow), 32'd1);

    // Fill to capacity, then overflow
    do_reset("r_full");
    for (int i = 0; i < CAP; i++) do_op(OP_PUSH, 16'(16'h0100 + i), "fill");
    chk("tp6.full", 32'(full), 32'd1);
    do_op(OP_PUSH, 16'h0BAD, "push_full");
    chk("tp6.overflow", 32'(overflow), 32'd1);
    chk("tp6.depth", 32'(depth), 32'(CAP));
    do_op(OP_DUP, 16'h0000, "dup_full");
    do_op(OP_OVER, 16'h0000, "over_full");
    for (int i = 0; i < CAP; i++) do_op(OP_POP, 16'h0000, "drain");

    // Asynchronous reset while a refill is in flight
    do_reset("r_ld");
    do_op(OP_PUSH, 16'h0A01, "ld_p1");
    do_op(OP_PUSH, 16'h0A02, "ld_p2");
    do_op(OP_PUSH, 16'h0A03, "ld_p3");
    @(negedge clock);
    op_valid = 1'b1;
    op       = OP_POP;
    @(negedge clock);
    op_valid = 1'b0;
    op       = OP_NOP;
    chk("rst_load.in_load", 32'(op_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_load.ready", 32'(op_ready), 32'd1);
    chk("rst_load.depth", 32'(depth), 32'd0);
    chk("rst_load.nos",   32'(nos), 32'd0);
    do_reset("r_after_ld");

`ifdef STACK_SYNC_CLEAR_EN
    do_op(OP_PUSH, 16'h0C01, "cl_p1");
    do_op(OP_PUSH, 16'h0C02, "cl_p2");
    do_op(OP_PUSH, 16'h0C03, "cl_p3");
    @(negedge clock);
    op_valid = 1'b1;
    op       = OP_POP;
    clear    = 1'b1;
    #1;
    chk("clear.mem_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    op_valid = 1'b0;
    op       = OP_NOP;
    clear    = 1'b0;
    stk.delete();
    check_state("clear");
    do_op(OP_PUSH, 16'h0D01, "cl_q1");
    do_op(OP_PUSH, 16'h0D02, "cl_q2");
    do_op(OP_PUSH, 16'h0D03, "cl_q3");
    do_op(OP_POP, 16'h0000, "cl_pop");
`endif

    // Randomized operation streams, restarting from reset so the sticky flags stay informative
    for (int blk = 0; blk < 6; blk++) begin
      do_reset("r_rand");
      for (int i = 0; i < 60; i++) begin
        ro = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 3) == 0) ro = OP_PUSH;
        do_op(ro, 16'($urandom), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
